hack_cpu_ctrl: RTL and testbench
================================

Name: hack_cpu_ctrl

Overview:
- Multi-cycle Hack CPU control and register stage.
- Fetches 16-bit Hack instructions over a ROM request/ready handshake and decodes them.
- Holds the A, D and PC registers and drives the operands and control bits of the external Hack ALU, then consumes the ALU result and flags.
- Performs data memory reads and writes over a RAM request/ready handshake, so it tolerates the SoC's wait-stated memories.

Parameters:
- ADDR_WIDTH, 15, ROM and RAM address width; also the PC width.
- RESET_PC, 0, PC value after reset.

Ports:
- clk  input  1  system clock
- reset_n  input  1  reset: synchronous, active-low
- rom_req  output  1  instruction fetch request
- rom_addr  output  ADDR_WIDTH  fetch address (equals PC)
- rom_ready  input  1  fetch complete; rom_data is valid on this cycle
- rom_data  input  16  instruction word
- mem_rd_req  output  1  data read request
- mem_wr_req  output  1  data write request
- mem_addr  output  ADDR_WIDTH  data address
- mem_wdata  output  16  write data
- mem_rdata  input  16  read data; valid when mem_ready is high
- mem_ready  input  1  data transfer complete
- alu_x  output  16  ALU x operand (D register)
- alu_y  output  16  ALU y operand (M if instruction bit 12 is 1, else A)
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  from instruction bits 11..6
- alu_out  input  16  ALU result
- alu_zr  input  1  ALU result is zero
- alu_ng  input  1  ALU result is negative
- pc  output  ADDR_WIDTH  current PC (debug)
- a_reg, d_reg  output  16  register contents (debug)
- instr_done  output  1  one-cycle pulse when an instruction retires

Behaviour:

Reset (reset_n low at a clk edge):
- state=FETCH, PC=RESET_PC, A=0, D=0, M latch=0, instruction register=0.
- All req outputs low, instr_done low.
- Takes effect at the next edge from any state; an in-flight request is abandoned and any late ready is ignored.

States and transitions:
- FETCH: rom_req=1, rom_addr=PC.
  - On an edge with rom_ready=1: latch rom_data into IR.
  - If rom_data[15]=0 (A-instruction), go to EXEC.
  - Else if rom_data[12]=1, go to MREAD; otherwise go to EXEC.
- MREAD: mem_rd_req=1, mem_addr=A.
  - On an edge with mem_ready=1: latch mem_rdata into M latch, go to EXEC.
- EXEC: one cycle.
  - A-instruction: A <= {1'b0, IR[14:0]}; PC <= PC+1; instr_done=1; go to FETCH.
  - C-instruction, dest bits d1=IR[5] (A), d2=IR[4] (D), d3=IR[3] (M):
    - A <= alu_out if d1; D <= alu_out if d2.
    - If d3: capture mem_addr_q <= old A and mem_wdata <= alu_out, then go to MWRITE.
    - Otherwise retire here (instr_done=1) and go to FETCH.
  - Jump: taken = (IR[2]&alu_ng) | (IR[1]&alu_zr) | (IR[0]&~alu_ng&~alu_zr).
    - Taken: PC <= old A[ADDR_WIDTH-1:0]. Not taken: PC <= PC+1.
    - Old A means the pre-EXEC value, even when d1 also writes A.
- MWRITE: mem_wr_req=1 with mem_addr and mem_wdata held stable.
  - On an edge with mem_ready=1: instr_done=1, go to FETCH.

Handshake rules:
- All req outputs are registered.
- A req stays high, with address and data stable, until ready is sampled high at an edge. The transfer completes at that edge and req drops in the next cycle unless the next state reasserts it.
- ready sampled while the corresponding req is low is ignored.
- Zero-wait ready (ready high in the first req cycle) is legal, so FETCH, MREAD and MWRITE each take at least 1 cycle.
- rom_req and the mem reqs are never high together.

Latency (zero-wait memories):
- A-instruction, or C-instruction without M: 2 cycles.
- Adds 1 cycle for an M read and 1 cycle for an M write.

Operand and width rules:
- alu_x and alu_y are driven combinationally from registers and are stable throughout EXEC.
- The ALU control outputs follow IR at all times; they are only meaningful in EXEC.
- PC+1 wraps from 2^ADDR_WIDTH-1 to 0.
- Data addresses use A[ADDR_WIDTH-1:0]; A[15] is ignored for addressing.

Simultaneous cases:
- d3 combined with a taken jump: the write completes first; the PC update still happens at EXEC.
- Destination AMD (d1, d2, d3 all set): all writes use the same alu_out.
- An M read followed by a D write of that same value is legal.

Test Plan:
- Reset, then zero-wait ROM returning 0x0005 -> rom_addr=0, then EXEC with A=0x0005, PC=1, instr_done pulses once; total 2 cycles.
- D=A (0xEC10) after loading A=0x1234 -> alu_y=0x1234, ALU controls 110000, D=0x1234, PC increments.
- M=D+1 (0xE7C8) with A=0x0010, D=0x00FF -> single mem_wr_req with mem_addr=0x0010 and mem_wdata=0x0100. Then with mem_ready delayed 3 cycles: req held for 4 cycles, then instr_done.
- D=M (0xFC10) with A=0x0020, mem_rdata=0xBEEF after a 2-cycle wait -> D=0xBEEF; the read req is held until ready.
- 0;JMP (0xEA87) with A=0x0100 -> PC=0x0100. D;JEQ (0xE302) with D≠0 -> PC+1. A-instruction at PC=0x7FFF -> PC wraps to 0.
- reset_n low during the MWRITE wait -> next cycle all reqs low, PC=0, A=D=0; a ready arriving afterwards is ignored.

Source files
------------

// File: rtl/hack_cpu_ctrl.sv
// Hack CPU control and register stage.
// Fetches and decodes Hack instructions, holds the A, D and PC registers,
// drives the external ALU, and moves data to and from RAM over
// request/ready handshakes so that wait-stated memories are tolerated.

module hack_cpu_ctrl #(
    parameter int                    ADDR_WIDTH = 15,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    // instruction fetch port
    output logic                  rom_req,
    output logic [ADDR_WIDTH-1:0] rom_addr,
    input  logic                  rom_ready,
    input  logic [15:0]           rom_data,
    // data memory port
    output logic                  mem_rd_req,
    output logic                  mem_wr_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [15:0]           mem_wdata,
    input  logic [15:0]           mem_rdata,
    input  logic                  mem_ready,
    // external ALU
    output logic [15:0]           alu_x,
    output logic [15:0]           alu_y,
    output logic                  alu_zx,
    output logic                  alu_nx,
    output logic                  alu_zy,
    output logic                  alu_ny,
    output logic                  alu_f,
    output logic                  alu_no,
    input  logic [15:0]           alu_out,
    input  logic                  alu_zr,
    input  logic                  alu_ng,
    // debug and status
    output logic [ADDR_WIDTH-1:0] pc,
    output logic [15:0]           a_reg,
    output logic [15:0]           d_reg,
    output logic                  instr_done
);

    typedef enum logic [1:0] {
        S_FETCH,
        S_MREAD,
        S_EXEC,
        S_MWRITE
    } state_t;

    state_t                  state;
    logic [15:0]             ir;
    logic [15:0]             m_latch;
    logic [ADDR_WIDTH-1:0]   pc_inc;
    logic                    jump_taken;

    // Next sequential PC, wrapping naturally at the top of the address space
    assign pc_inc = pc + ADDR_WIDTH'(1);

    // Jump condition from the instruction jump bits and the live ALU flags
    assign jump_taken = (ir[2] & alu_ng) | (ir[1] & alu_zr) | (ir[0] & ~alu_ng & ~alu_zr);

    // Operands come straight from the registers so they are stable for all of EXEC
    assign alu_x    = d_reg;
    assign alu_y    = ir[12] ? m_latch : a_reg;
    assign alu_zx   = ir[11];
    assign alu_nx   = ir[10];
    assign alu_zy   = ir[9];
    assign alu_ny   = ir[8];
    assign alu_f    = ir[7];
    assign alu_no   = ir[6];
    assign rom_addr = pc;

    // Main control FSM; every request and the retire pulse are registered here.
    // After reset the FETCH state first raises rom_req, so a ready seen while
    // a request is low is never taken as a transfer.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state      <= S_FETCH;
            pc         <= RESET_PC;
            a_reg      <= '0;
            d_reg      <= '0;
            m_latch    <= '0;
            ir         <= '0;
            rom_req    <= 1'b0;
            mem_rd_req <= 1'b0;
            mem_wr_req <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            instr_done <= 1'b0;
        end else begin
            instr_done <= 1'b0;
            case (state)
                S_FETCH: begin
                    if (!rom_req) begin
                        rom_req <= 1'b1;
                    end else if (rom_ready) begin
                        ir      <= rom_data;
                        rom_req <= 1'b0;
                        if (rom_data[15] && rom_data[12]) begin
                            mem_rd_req <= 1'b1;
                            mem_addr   <= a_reg[ADDR_WIDTH-1:0];
                            state      <= S_MREAD;
                        end else begin
                            state <= S_EXEC;
                        end
                    end
                end

                S_MREAD: begin
                    if (mem_ready) begin
                        m_latch    <= mem_rdata;
                        mem_rd_req <= 1'b0;
                        state      <= S_EXEC;
                    end
                end

                S_EXEC: begin
                    if (!ir[15]) begin
                        a_reg      <= {1'b0, ir[14:0]};
                        pc         <= pc_inc;
                        instr_done <= 1'b1;
                        rom_req    <= 1'b1;
                        state      <= S_FETCH;
                    end else begin
                        if (ir[5]) begin
                            a_reg <= alu_out;
                        end
                        if (ir[4]) begin
                            d_reg <= alu_out;
                        end
                        // Jump target and write address both use A as it was before this cycle
                        pc <= jump_taken ? a_reg[ADDR_WIDTH-1:0] : pc_inc;
                        if (ir[3]) begin
                            mem_addr   <= a_reg[ADDR_WIDTH-1:0];
                            mem_wdata  <= alu_out;
                            mem_wr_req <= 1'b1;
                            state      <= S_MWRITE;
                        end else begin
                            instr_done <= 1'b1;
                            rom_req    <= 1'b1;
                            state      <= S_FETCH;
                        end
                    end
                end

                S_MWRITE: begin
                    if (mem_ready) begin
                        mem_wr_req <= 1'b0;
                        instr_done <= 1'b1;
                        rom_req    <= 1'b1;
                        state      <= S_FETCH;
                    end
                end

                default: begin
                    state <= S_FETCH;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hack_cpu_ctrl.sv
// Scoreboard testbench for hack_cpu_ctrl: a driver plays ROM and RAM with
// configurable wait states while a monitor checks fetches, memory transfers
// and retired-instruction register state against queued expectations.

module tb_hack_cpu_ctrl;

    logic        clk;
    logic        reset_n;
    logic        rom_req;
    logic [14:0] rom_addr;
    logic        rom_ready;
    logic [15:0] rom_data;
    logic        mem_rd_req;
    logic        mem_wr_req;
    logic [14:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ready;
    logic [15:0] alu_x;
    logic [15:0] alu_y;
    logic        alu_zx;
    logic        alu_nx;
    logic        alu_zy;
    logic        alu_ny;
    logic        alu_f;
    logic        alu_no;
    logic [15:0] alu_out;
    logic        alu_zr;
    logic        alu_ng;
    logic [14:0] pc;
    logic [15:0] a_reg;
    logic [15:0] d_reg;
    logic        instr_done;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [15:0] instr;
        int          rom_wait;
        int          rd_wait;
        logic [15:0] rdata;
        int          wr_wait;
        logic [14:0] fetch_pc;
        bit          has_rd;
        logic [14:0] rd_addr;
        bit          has_wr;
        logic [14:0] wr_addr;
        logic [15:0] wr_data;
        logic [14:0] exp_pc;
        logic [15:0] exp_a;
        logic [15:0] exp_d;
        bit          chk_alu;
        logic [5:0]  ctrl;
        logic [15:0] exp_alu_y;
        int          cycles;
    } vec_t;

    typedef struct {
        logic [14:0] pc;
        logic [15:0] a;
        logic [15:0] d;
        bit          chk_alu;
        logic [5:0]  ctrl;
        logic [15:0] alu_y;
    } retire_t;

    typedef struct {
        logic [14:0] addr;
        logic [15:0] data;
    } write_t;

    logic [14:0] fetch_q[$];
    logic [14:0] read_q[$];
    write_t      write_q[$];
    retire_t     retire_q[$];

    vec_t prog [0:18];

    hack_cpu_ctrl #(
        .ADDR_WIDTH (15),
        .RESET_PC   (15'd0)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rom_req    (rom_req),
        .rom_addr   (rom_addr),
        .rom_ready  (rom_ready),
        .rom_data   (rom_data),
        .mem_rd_req (mem_rd_req),
        .mem_wr_req (mem_wr_req),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_rdata  (mem_rdata),
        .mem_ready  (mem_ready),
        .alu_x      (alu_x),
        .alu_y      (alu_y),
        .alu_zx     (alu_zx),
        .alu_nx     (alu_nx),
        .alu_zy     (alu_zy),
        .alu_ny     (alu_ny),
        .alu_f      (alu_f),
        .alu_no     (alu_no),
        .alu_out    (alu_out),
        .alu_zr     (alu_zr),
        .alu_ng     (alu_ng),
        .pc         (pc),
        .a_reg      (a_reg),
        .d_reg      (d_reg),
        .instr_done (instr_done)
    );

    // Free-running clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // External Hack ALU that the controller drives
    always_comb begin
        logic [15:0] x;
        logic [15:0] y;
        logic [15:0] o;
        x = alu_x;
        y = alu_y;
        if (alu_zx) x = 16'h0000;
        if (alu_nx) x = ~x;
        if (alu_zy) y = 16'h0000;
        if (alu_ny) y = ~y;
        o = alu_f ? (x + y) : (x & y);
        if (alu_no) o = ~o;
        alu_out = o;
        alu_zr  = (o == 16'h0000);
        alu_ng  = o[15];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic reportFail(input string name);
        checks++;
        errors++;
        $display("[TB] FAIL %s: got no event, expected one", name);
    endtask

    // Monitor: compares every transfer and retirement against the scoreboard
    always @(negedge clk) begin
        if (reset_n) begin
            checkOutput("req exclusive", 32'(rom_req & (mem_rd_req | mem_wr_req)), 32'd0);
            if (rom_req && rom_ready) begin
                if (fetch_q.size() == 0) begin
                    reportFail("unexpected fetch");
                end else begin
                    checkOutput("fetch rom_addr", 32'(rom_addr), 32'(fetch_q.pop_front()));
                end
            end
            if (mem_rd_req && mem_ready) begin
                if (read_q.size() == 0) begin
                    reportFail("unexpected read");
                end else begin
                    checkOutput("read mem_addr", 32'(mem_addr), 32'(read_q.pop_front()));
                end
            end
            if (mem_wr_req && mem_ready) begin
                if (write_q.size() == 0) begin
                    reportFail("unexpected write");
                end else begin
                    write_t w;
                    w = write_q.pop_front();
                    checkOutput("write mem_addr", 32'(mem_addr), 32'(w.addr));
                    checkOutput("write mem_wdata", 32'(mem_wdata), 32'(w.data));
                end
            end
            if (instr_done) begin
                if (retire_q.size() == 0) begin
                    reportFail("unexpected retire");
                end else begin
                    retire_t r;
                    r = retire_q.pop_front();
                    checkOutput("retire pc", 32'(pc), 32'(r.pc));
                    checkOutput("retire a_reg", 32'(a_reg), 32'(r.a));
                    checkOutput("retire d_reg", 32'(d_reg), 32'(r.d));
                    if (r.chk_alu) begin
                        checkOutput("alu controls", 32'({alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no}), 32'(r.ctrl));
                        checkOutput("alu_y", 32'(alu_y), 32'(r.alu_y));
                    end
                end
            end
        end
    end

    // Bounded wait for the controller to request an instruction
    task automatic waitRomReq();
        int n = 0;
        while (!rom_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!rom_req) reportFail("rom_req timeout");
    endtask

    // Queue the expectations of one instruction, then act as ROM and RAM until it retires
    task automatic applyStimulus(input vec_t v);
        int  cyc     = 0;
        int  rw      = 0;
        int  dw      = 0;
        int  ww      = 0;
        int  wr_hold = 0;
        bit  done    = 1'b0;
        retire_t r;
        r = '{v.exp_pc, v.exp_a, v.exp_d, v.chk_alu, v.ctrl, v.exp_alu_y};
        fetch_q.push_back(v.fetch_pc);
        if (v.has_rd) read_q.push_back(v.rd_addr);
        if (v.has_wr) write_q.push_back('{v.wr_addr, v.wr_data});
        retire_q.push_back(r);
        waitRomReq();
        while (!done && cyc < 100) begin
            rom_ready = 1'b0;
            mem_ready = 1'b0;
            mem_rdata = 16'hDEAD;
            if (rom_req) begin
                if (rw == v.rom_wait) begin
                    rom_ready = 1'b1;
                    rom_data  = v.instr;
                end else begin
                    rom_data = 16'hFFFF;
                    rw++;
                end
            end
            if (mem_rd_req) begin
                if (dw == v.rd_wait) begin
                    mem_ready = 1'b1;
                    mem_rdata = v.rdata;
                end else begin
                    dw++;
                end
            end
            if (mem_wr_req) begin
                wr_hold++;
                if (ww == v.wr_wait) mem_ready = 1'b1;
                else ww++;
            end
            @(posedge clk); #1;
            cyc++;
            if (instr_done) done = 1'b1;
        end
        rom_ready = 1'b0;
        mem_ready = 1'b0;
        if (!done) begin
            reportFail("retire timeout");
        end else begin
            checkOutput("instruction cycles", 32'(cyc), 32'(v.cycles));
            if (v.has_wr) checkOutput("write req hold cycles", 32'(wr_hold), 32'(v.wr_wait + 1));
        end
    endtask

    initial begin
        int n;
        reset_n   = 1'b0;
        rom_ready = 1'b0;
        rom_data  = 16'h0000;
        mem_ready = 1'b0;
        mem_rdata = 16'h0000;

        //           instr     romw rdw rdata     wrw fetch     rd    rdaddr    wr    wraddr    wrdata    pc        a         d         chk   ctrl       alu_y     cyc
        prog[0]  = '{16'h0005, 0,   0,  16'h0000, 0,  15'h0000, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0001, 16'h0005, 16'h0000, 1'b0, 6'b000000, 16'h0000, 2};
        prog[1]  = '{16'h1234, 2,   0,  16'h0000, 0,  15'h0001, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0002, 16'h1234, 16'h0000, 1'b0, 6'b000000, 16'h0000, 4};
        prog[2]  = '{16'hEC10, 0,   0,  16'h0000, 0,  15'h0002, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0003, 16'h1234, 16'h1234, 1'b1, 6'b110000, 16'h1234, 2};
        prog[3]  = '{16'h0010, 0,   0,  16'h0000, 0,  15'h0003, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0004, 16'h0010, 16'h1234, 1'b0, 6'b000000, 16'h0000, 2};
        prog[4]  = '{16'h00FF, 0,   0,  16'h0000, 0,  15'h0004, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0005, 16'h00FF, 16'h1234, 1'b0, 6'b000000, 16'h0000, 2};
        prog[5]  = '{16'hEC10, 0,   0,  16'h0000, 0,  15'h0005, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0006, 16'h00FF, 16'h00FF, 1'b1, 6'b110000, 16'h00FF, 2};
        prog[6]  = '{16'h0010, 0,   0,  16'h0000, 0,  15'h0006, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0007, 16'h0010, 16'h00FF, 1'b0, 6'b000000, 16'h0000, 2};
        prog[7]  = '{16'hE7C8, 0,   0,  16'h0000, 0,  15'h0007, 1'b0, 15'h0000, 1'b1, 15'h0010, 16'h0100, 15'h0008, 16'h0010, 16'h00FF, 1'b1, 6'b011111, 16'h0010, 3};
        prog[8]  = '{16'hE7C8, 0,   0,  16'h0000, 3,  15'h0008, 1'b0, 15'h0000, 1'b1, 15'h0010, 16'h0100, 15'h0009, 16'h0010, 16'h00FF, 1'b0, 6'b000000, 16'h0000, 6};
        prog[9]  = '{16'h0020, 0,   0,  16'h0000, 0,  15'h0009, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h000A, 16'h0020, 16'h00FF, 1'b0, 6'b000000, 16'h0000, 2};
        prog[10] = '{16'hFC10, 0,   2,  16'hBEEF, 0,  15'h000A, 1'b1, 15'h0020, 1'b0, 15'h0000, 16'h0000, 15'h000B, 16'h0020, 16'hBEEF, 1'b1, 6'b110000, 16'hBEEF, 5};
        prog[11] = '{16'h0100, 0,   0,  16'h0000, 0,  15'h000B, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h000C, 16'h0100, 16'hBEEF, 1'b0, 6'b000000, 16'h0000, 2};
        prog[12] = '{16'hEA87, 0,   0,  16'h0000, 0,  15'h000C, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0100, 16'h0100, 16'hBEEF, 1'b1, 6'b101010, 16'h0100, 2};
        prog[13] = '{16'hE302, 0,   0,  16'h0000, 0,  15'h0100, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0101, 16'h0100, 16'hBEEF, 1'b1, 6'b001100, 16'h0100, 2};
        prog[14] = '{16'h0007, 0,   0,  16'h0000, 0,  15'h0101, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0102, 16'h0007, 16'hBEEF, 1'b0, 6'b000000, 16'h0000, 2};
        prog[15] = '{16'hEDFF, 0,   0,  16'h0000, 1,  15'h0102, 1'b0, 15'h0000, 1'b1, 15'h0007, 16'h0008, 15'h0007, 16'h0008, 16'h0008, 1'b1, 6'b110111, 16'h0008, 4};
        prog[16] = '{16'h7FFF, 0,   0,  16'h0000, 0,  15'h0007, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0008, 16'h7FFF, 16'h0008, 1'b0, 6'b000000, 16'h0000, 2};
        prog[17] = '{16'hEA87, 0,   0,  16'h0000, 0,  15'h0008, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h7FFF, 16'h7FFF, 16'h0008, 1'b0, 6'b000000, 16'h0000, 2};
        prog[18] = '{16'h0003, 0,   0,  16'h0000, 0,  15'h7FFF, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0000, 16'h0003, 16'h0008, 1'b0, 6'b000000, 16'h0000, 2};

        repeat (3) @(posedge clk);
        #1;
        $display("[TB] checking reset state");
        checkOutput("reset rom_req", 32'(rom_req), 32'd0);
        checkOutput("reset mem_rd_req", 32'(mem_rd_req), 32'd0);
        checkOutput("reset mem_wr_req", 32'(mem_wr_req), 32'd0);
        checkOutput("reset instr_done", 32'(instr_done), 32'd0);
        checkOutput("reset pc", 32'(pc), 32'd0);
        checkOutput("reset a_reg", 32'(a_reg), 32'd0);
        checkOutput("reset d_reg", 32'(d_reg), 32'd0);
        reset_n = 1'b1;

        $display("[TB] running directed program");
        for (int i = 0; i < 19; i++) begin
            applyStimulus(prog[i]);
        end

        // M=D+1 with a stalled write, then reset while the write is pending
        $display("[TB] reset during pending write");
        fetch_q.push_back(15'h0000);
        waitRomReq();
        rom_data  = 16'hE7C8;
        rom_ready = 1'b1;
        @(posedge clk); #1;
        rom_ready = 1'b0;
        n = 0;
        while (!mem_wr_req && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (!mem_wr_req) reportFail("mem_wr_req timeout");
        repeat (2) @(posedge clk);
        #1;
        checkOutput("pending write req held", 32'(mem_wr_req), 32'd1);
        reset_n = 1'b0;
        @(posedge clk); #1;
        checkOutput("abort rom_req", 32'(rom_req), 32'd0);
        checkOutput("abort mem_wr_req", 32'(mem_wr_req), 32'd0);
        checkOutput("abort mem_rd_req", 32'(mem_rd_req), 32'd0);
        checkOutput("abort pc", 32'(pc), 32'd0);
        checkOutput("abort a_reg", 32'(a_reg), 32'd0);
        checkOutput("abort d_reg", 32'(d_reg), 32'd0);
        reset_n   = 1'b1;
        mem_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            checkOutput("late ready mem_wr_req", 32'(mem_wr_req), 32'd0);
            checkOutput("late ready instr_done", 32'(instr_done), 32'd0);
        end
        mem_ready = 1'b0;

        applyStimulus('{16'h0009, 0, 0, 16'h0000, 0, 15'h0000, 1'b0, 15'h0000, 1'b0, 15'h0000, 16'h0000, 15'h0001, 16'h0009, 16'h0000, 1'b0, 6'b000000, 16'h0000, 2});

        repeat (2) @(posedge clk);
        checkOutput("fetch queue drained", 32'(fetch_q.size()), 32'd0);
        checkOutput("read queue drained", 32'(read_q.size()), 32'd0);
        checkOutput("write queue drained", 32'(write_q.size()), 32'd0);
        checkOutput("retire queue drained", 32'(retire_q.size()), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
